div_sequencer: RTL and testbench

Controller that sequences the iterative multi-cycle divider from the EX stage of the 5-stage MIPS pipeline.
- Accepts a DIV/DIVU held in EX and launches the divider with registered operands.
- Stalls IF/ID/EX until the 64-bit {HI,LO} result is ready, then presents it to the EX→ME register.
- Handles flush (annul), divide-by-zero and a watchdog timeout.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/div_sequencer.sv | 112 +++++++++++
 tb/tb_div_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the EX-stage divide sequencer.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
  localparam logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF;
  localparam int DIV_MAX_CYCLES = 40;
  function automatic int cnt_width(input int max_cycles);
    return $clog2(max_cycles + 1);
  endfunction
endpackage

// File: rtl/div_sequencer.sv
// div_sequencer: launches the iterative divider for a DIV/DIVU in EX, stalls the
// front end until {HI,LO} is ready, and handles flush, divide-by-zero and watchdog.
module div_sequencer
  import cpu_pkg::*;
#(
  parameter int MAX_CYCLES = DIV_MAX_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_reqE,
  input  logic        div_signedE,
  input  logic [31:0] opaE,
  input  logic [31:0] opbE,
  input  logic        flushE,
  input  logic        holdM,
  output logic        div_start,
  output logic        div_annul,
  output logic        div_signed,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        stall_div,
  output logic        result_valid,
  output logic [63:0] resultE,
  output logic        div_timeout
);
  localparam int CW = cnt_width(MAX_CYCLES);
  div_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic [63:0] res_q, res_d;
  logic sgn_q, sgn_d, start_q, start_d, annul_q, annul_d, to_q, to_d;
  logic accept;
  assign accept = div_reqE & ~flushE;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sgn_d   = sgn_q;
    res_d   = res_q;
    to_d    = to_q;
    start_d = 1'b0;
    annul_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && opbE != 32'd0) begin
          opa_d   = opaE;
          opb_d   = opbE;
          sgn_d   = div_signedE;
          cnt_d   = '0;
          start_d = 1'b1;
          state_d = RUN;
        end else if (accept) begin
          res_d   = {opaE, DIVZERO_LO};
          state_d = DONE;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        // a divider that finished in the flush cycle needs no abort
        if (flushE) begin
          annul_d = ~div_ready;
          state_d = IDLE;
        end else if (div_ready) begin
          res_d   = div_result;
          state_d = DONE;
        end else if (cnt_q == CW'(MAX_CYCLES - 1)) begin
          annul_d = 1'b1;
          res_d   = '0;
          to_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = (flushE || !holdM) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sgn_q   <= 1'b0;
      res_q   <= '0;
      to_q    <= 1'b0;
      start_q <= 1'b0;
      annul_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
      res_q   <= res_d;
      to_q    <= to_d;
      start_q <= start_d;
      annul_q <= annul_d;
    end
  end
  assign div_start    = start_q;
  assign div_annul    = annul_q;
  assign div_signed   = sgn_q;
  assign div_opa      = opa_q;
  assign div_opb      = opb_q;
  assign resultE      = res_q;
  assign div_timeout  = to_q;
  assign result_valid = state_q == DONE;
  assign stall_div    = state_q == RUN || (state_q == IDLE && accept);
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: randomized transaction-level check of div_sequencer against a
// timing/arithmetic reference model with a behavioural divider responder.
module tb_div_sequencer;
  logic clk = 1'b0;
  logic rst, div_reqE, div_signedE, flushE, holdM, div_ready;
  logic [31:0] opaE, opbE;
  logic [63:0] div_result;
  logic div_start, div_annul, div_signed, stall_div, result_valid, div_timeout;
  logic [31:0] div_opa, div_opb;
  logic [63:0] resultE;
  int total = 0, bad = 0, txn = 0;
  bit exp_to = 1'b0;
  always #5 clk = ~clk;
  div_sequencer #(.MAX_CYCLES(40)) dut (
    .clk(clk), .rst(rst), .div_reqE(div_reqE), .div_signedE(div_signedE),
    .opaE(opaE), .opbE(opbE), .flushE(flushE), .holdM(holdM),
    .div_start(div_start), .div_annul(div_annul), .div_signed(div_signed),
    .div_opa(div_opa), .div_opb(div_opb), .div_result(div_result),
    .div_ready(div_ready), .stall_div(stall_div), .result_valid(result_valid),
    .resultE(resultE), .div_timeout(div_timeout)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sg) return {a % b, a / b};
    sa = a;
    sb = b;
    sq = sa / sb;
    sr = sa % sb;
    return {sr, sq};
  endfunction
  // lat: divider cycles counting the start cycle (0 = never answers); frc: RUN cycle index to flush (-1 none)
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input int lat, input int frc, input int hold);
    int rdy = -1, n_start = 0, start_cyc = -1, n_stall = 0, n_annul = 0, annul_cyc = -1;
    int v_first = -1, v_len = 0, hold_left = hold, fcyc;
    int e_stall, e_annul, e_acyc, e_vfirst, e_vlen;
    logic [63:0] v_res = '0, e_res;
    bit ops_ok = 1, stable = 1, gone = 0, done = 0;
    bit zero = (b == 32'd0);
    bit to = !zero && lat == 0 && frc < 0;
    string p;
    txn++;
    p = $sformatf("t%0d", txn);
    fcyc = (zero || frc < 0) ? -1 : frc + 1;
    for (int i = 0; i < 90 && !done; i++) begin
      @(negedge clk);
      if (div_start) begin
        n_start++;
        start_cyc = i;
        if (div_opa !== a || div_opb !== b || div_signed !== sg) ops_ok = 0;
        if (lat > 0) rdy = i + lat - 1;
      end
      if (div_annul) begin
        n_annul++;
        annul_cyc = i;
        rdy = -1;
      end
      if (result_valid) begin
        if (v_first < 0) begin
          v_first = i;
          v_res = resultE;
        end else if (resultE !== v_res) stable = 0;
        v_len++;
      end
      done = gone;
      div_reqE = !gone;
      opaE = a;
      opbE = b;
      div_signedE = sg;
      flushE = (i == fcyc);
      holdM = result_valid ? (hold_left > 0) : 1'($urandom_range(0, 1));
      if (result_valid && hold_left > 0) hold_left--;
      div_ready = (i == rdy);
      div_result = ref_div(a, b, sg);
      if (i == fcyc || (result_valid && !holdM)) gone = 1;
      #1;
      if (stall_div) n_stall++;
    end
    div_reqE = 1'b0;
    flushE = 1'b0;
    div_ready = 1'b0;
    if (to) exp_to = 1'b1;
    e_res = zero ? {a, 32'hFFFF_FFFF} : to ? 64'd0 : ref_div(a, b, sg);
    e_stall = zero ? 1 : fcyc >= 0 ? fcyc + 1 : to ? 41 : lat + 1;
    e_annul = (fcyc >= 0) ? ((lat > 0 && frc == lat - 1) ? 0 : 1) : (to ? 1 : 0);
    e_acyc = e_annul == 0 ? -1 : (fcyc >= 0 ? fcyc + 1 : 41);
    e_vfirst = fcyc >= 0 ? -1 : zero ? 1 : to ? 41 : lat + 1;
    e_vlen = fcyc >= 0 ? 0 : hold + 1;
    check({p, "_finished"}, 64'(done), 64'd1);
    check({p, "_nstart"}, 64'(n_start), zero ? 64'd0 : 64'd1);
    if (!zero) check({p, "_start_cyc"}, 64'(start_cyc), 64'd1);
    if (!zero) check({p, "_operands"}, 64'(ops_ok), 64'd1);
    check({p, "_stall_cycles"}, 64'(n_stall), 64'(e_stall));
    check({p, "_annul_count"}, 64'(n_annul), 64'(e_annul));
    check({p, "_annul_cyc"}, 64'(annul_cyc), 64'(e_acyc));
    check({p, "_valid_first"}, 64'(v_first), 64'(e_vfirst));
    check({p, "_valid_len"}, 64'(v_len), 64'(e_vlen));
    if (fcyc < 0) check({p, "_result"}, v_res, e_res);
    if (fcyc < 0) check({p, "_result_stable"}, 64'(stable), 64'd1);
    check({p, "_timeout"}, 64'(div_timeout), 64'(exp_to));
  endtask
  task automatic check_zero_outputs(input string tag);
    check({tag, "_start"}, 64'(div_start), 64'd0);
    check({tag, "_annul"}, 64'(div_annul), 64'd0);
    check({tag, "_signed"}, 64'(div_signed), 64'd0);
    check({tag, "_opa"}, 64'(div_opa), 64'd0);
    check({tag, "_opb"}, 64'(div_opb), 64'd0);
    check({tag, "_valid"}, 64'(result_valid), 64'd0);
    check({tag, "_result"}, resultE, 64'd0);
    check({tag, "_timeout"}, 64'(div_timeout), 64'd0);
    check({tag, "_stall"}, 64'(stall_div), 64'd0);
  endtask
  initial begin
    logic [31:0] a, b;
    logic sg;
    int kind, lat, frc;
    rst = 1'b0;
    {div_reqE, div_signedE, flushE, holdM, div_ready} = '0;
    opaE = '0;
    opbE = '0;
    div_result = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero_outputs("reset");
    run_div(32'd100, 32'd7, 1'b0, 33, -1, 0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 33, -1, 0);
    check("neg7div2", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), 64'hFFFF_FFFF_FFFF_FFFD);
    run_div(32'd5, 32'd0, 1'b1, 33, -1, 0);
    run_div(32'd1234, 32'd10, 1'b0, 33, 9, 0);
    run_div(32'd99, 32'd3, 1'b0, 20, -1, 0);
    run_div(32'd77, 32'd5, 1'b1, 5, 4, 0);
    run_div(32'd1000, 32'd9, 1'b0, 40, -1, 1);
    run_div(32'd50, 32'd6, 1'b0, 0, -1, 0);
    run_div(32'hDEAD_BEEF, 32'h1234, 1'b0, 33, -1, 3);
    run_div(32'd8, 32'd0, 1'b0, 1, -1, 2);
    run_div(32'd17, 32'd4, 1'b1, 1, -1, 0);
    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a = $urandom;
      b = $urandom;
      sg = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 19);
      if (kind < 3) b = 32'd0;
      else if (b == 32'd0) b = 32'd3;
      if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      if (kind == 6) lat = 0;
      else lat = $urandom_range(1, 40);
      frc = (kind >= 3 && kind <= 5) ? (lat > 0 ? $urandom_range(0, lat - 1) : $urandom_range(0, 39)) : -1;
      run_div(a, b, sg, lat, frc, $urandom_range(0, 3));
    end
    @(negedge clk);
    div_reqE = 1'b1;
    opaE = 32'd300;
    opbE = 32'd11;
    div_signedE = 1'b1;
    repeat (6) @(negedge clk);
    check("midrun_stall", 64'(stall_div), 64'd1);
    rst = 1'b0;
    div_reqE = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_to = 1'b0;
    #1;
    check_zero_outputs("midrun_reset");
    run_div(32'd300, 32'd11, 1'b1, 33, -1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
